// File: rtl/pcw_daisy_pkg.sv
// Shared types and constants for the PCW daisywheel/printer controller emulation.
package pcw_daisy_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PARAM = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Upper nibble of every status byte read from port FD.
  localparam logic [3:0] STATUS_NIBBLE = 4'b1011;

  // Bus register map as seen through the 2-bit address.
  localparam logic [1:0] ADDR_DATA = 2'b00;
  localparam logic [1:0] ADDR_CMD  = 2'b10;

  // Command codes the emulated controller recognises.
  localparam logic [7:0] CMD_NOP     = 8'h00;
  localparam logic [7:0] CMD_C02     = 8'h02;
  localparam logic [7:0] CMD_C06     = 8'h06;
  localparam logic [7:0] CMD_C0A     = 8'h0A;
  localparam logic [7:0] CMD_C0B     = 8'h0B;
  localparam logic [7:0] CMD_C12     = 8'h12;
  localparam logic [7:0] CMD_VERSION = 8'h20;

  // Per-command shape: parameter bytes expected, response bytes produced.
  typedef struct packed {
    logic [1:0] nparam;
    logic [1:0] nresp;
  } cmd_info_t;

endpackage

// File: rtl/pcw_daisy_ctrl_if.sv
// CPU-side bus of the daisywheel controller: strobes, address, data and busy.
interface pcw_daisy_ctrl_if;

  logic       ce;
  logic       sel;
  logic [1:0] address;
  logic       wr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       busy;

  modport master (
    output ce, sel, address, wr, din,
    input  dout, busy
  );

  modport slave (
    input  ce, sel, address, wr, din,
    output dout, busy
  );

endinterface

// File: rtl/pcw_daisy_cmd_rom.sv
// Command table: maps a command code and response index to the command shape
// and the response byte to emit at that index.
module pcw_daisy_cmd_rom
  import pcw_daisy_pkg::*;
#(
  parameter logic [7:0] FW_VERSION = 8'h21
) (
  input  logic [7:0] cmd_i,
  input  logic [1:0] resp_idx_i,
  output cmd_info_t  info_o,
  output logic [7:0] resp_byte_o
);

  // Unknown commands take one parameter and answer a single 0xFF.
  always_comb begin
    info_o      = '{nparam: 2'd1, nresp: 2'd1};
    resp_byte_o = 8'hFF;
    case (cmd_i)
      CMD_C02, CMD_C06, CMD_C0A, CMD_C0B, CMD_C12: begin
        info_o      = '{nparam: 2'd1, nresp: 2'd1};
        resp_byte_o = 8'h00;
      end
      CMD_VERSION: begin
        info_o      = '{nparam: 2'd0, nresp: 2'd2};
        resp_byte_o = (resp_idx_i == 2'd0) ? 8'h00 : FW_VERSION;
      end
      CMD_NOP: begin
        info_o      = '{nparam: 2'd0, nresp: 2'd0};
        resp_byte_o = 8'hFF;
      end
      default: begin
        info_o      = '{nparam: 2'd1, nresp: 2'd1};
        resp_byte_o = 8'hFF;
      end
    endcase
  end

endmodule

// File: rtl/pcw_daisy_ctrl.sv
// Daisywheel/printer controller emulation on the PCW I/O bus (FC data,
// FD status, 01FC command): command parser, timed busy phase and a
// response FIFO the CPU drains through the data port.
module pcw_daisy_ctrl
  import pcw_daisy_pkg::*;
#(
  parameter int unsigned RESP_DEPTH  = 8,
  parameter int unsigned BUSY_CYCLES = 16,
  parameter logic [7:0]  FW_VERSION  = 8'h21
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  pcw_daisy_ctrl_if.slave   bus
);

  localparam int PTR_W = $clog2(RESP_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(BUSY_CYCLES + 1);

  state_e           state_q;
  logic             busy_q;
  logic             ovf_q;
  logic             old_sel_q;
  logic [7:0]       cmd_q;
  logic [1:0]       pcount_q;
  logic [TMR_W-1:0] timer_q;
  logic [1:0]       resp_idx_q;

  logic [7:0]       fifo_q [RESP_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic             acc;
  logic             cmd_wr;
  logic             data_wr;
  logic             avail;
  logic             full;
  logic             pop;
  logic             push;
  logic             ready;
  logic [7:0]       status;
  logic [7:0]       rom_cmd;
  cmd_info_t        info;
  logic [7:0]       resp_byte;

  // One access per rising edge of sel, qualified by the CPU clock enable.
  assign acc     = bus.ce & bus.sel & ~old_sel_q;
  assign cmd_wr  = acc & bus.wr & (bus.address == ADDR_CMD);
  assign data_wr = acc & bus.wr & (bus.address == ADDR_DATA);

  assign avail = (count_q != '0);
  assign full  = (count_q == CNT_W'(RESP_DEPTH));
  assign ready = (state_q == IDLE) & ~avail;
  assign status = {STATUS_NIBBLE, ovf_q, busy_q, ready, avail};

  assign pop  = acc & ~bus.wr & (bus.address == ADDR_DATA) & avail;
  assign push = bus.ce & (state_q == RESP) & ~cmd_wr & ~full
              & (resp_idx_q < info.nresp);

  // A new command is decoded straight off the bus; otherwise the table
  // describes the command currently in progress.
  assign rom_cmd = cmd_wr ? bus.din : cmd_q;

  pcw_daisy_cmd_rom #(
    .FW_VERSION (FW_VERSION)
  ) u_cmd_rom (
    .cmd_i       (rom_cmd),
    .resp_idx_i  (resp_idx_q),
    .info_o      (info),
    .resp_byte_o (resp_byte)
  );

  assign bus.busy = busy_q;

  // Read mux: data port shows the FIFO head during the access, else status.
  always_comb begin
    bus.dout = 8'hFF;
    if (bus.sel & bus.ce) begin
      if (!bus.wr && !bus.address[0]) begin
        bus.dout = avail ? fifo_q[rd_ptr_q] : 8'hFF;
      end else begin
        bus.dout = status;
      end
    end
  end

  // Response storage; emptiness is tracked by count, so no reset is needed.
  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= resp_byte;
    end
  end

  // FIFO pointers and count; a command write flushes any stale responses.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (cmd_wr) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Command sequencer: collect parameters, wait out the busy time, then
  // stream the response bytes into the FIFO.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      old_sel_q  <= 1'b0;
      cmd_q      <= CMD_NOP;
      pcount_q   <= 2'd0;
      timer_q    <= '0;
      resp_idx_q <= 2'd0;
    end else if (bus.ce) begin
      old_sel_q <= bus.sel;
      if (cmd_wr) begin
        cmd_q      <= bus.din;
        ovf_q      <= 1'b0;
        pcount_q   <= info.nparam;
        resp_idx_q <= 2'd0;
        busy_q     <= 1'b1;
        if (info.nparam == 2'd0) begin
          state_q <= BUSY;
          timer_q <= TMR_W'(BUSY_CYCLES);
        end else begin
          state_q <= PARAM;
        end
      end else begin
        if (data_wr && (state_q != PARAM)) begin
          ovf_q <= 1'b1;
        end
        case (state_q)
          IDLE: begin
            busy_q <= 1'b0;
          end
          PARAM: begin
            if (data_wr) begin
              pcount_q <= pcount_q - 2'd1;
              if (pcount_q == 2'd1) begin
                state_q <= BUSY;
                timer_q <= TMR_W'(BUSY_CYCLES);
              end
            end
          end
          BUSY: begin
            timer_q <= timer_q - TMR_W'(1);
            if (timer_q == TMR_W'(1)) begin
              state_q    <= RESP;
              resp_idx_q <= 2'd0;
            end
          end
          RESP: begin
            if (resp_idx_q >= info.nresp) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else if (push) begin
              resp_idx_q <= resp_idx_q + 2'd1;
              if (resp_idx_q == (info.nresp - 2'd1)) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pcw_daisy_ctrl.sv
// Self-checking bench for pcw_daisy_ctrl: expected response bytes are queued
// when a command completes on the bus and consumed as the CPU reads port FC.
module tb_pcw_daisy_ctrl;

  localparam int unsigned BUSY_CYCLES = 16;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;

  pcw_daisy_ctrl_if bus ();

  pcw_daisy_ctrl #(
    .RESP_DEPTH  (8),
    .BUSY_CYCLES (BUSY_CYCLES),
    .FW_VERSION  (8'h21)
  ) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Free-running system clock.
  always #5 clk_sys = ~clk_sys;

  int         checkCount = 0;
  int         failCount  = 0;
  logic [7:0] expQ [$];
  logic [7:0] rdata;
  logic [7:0] pendCmd    = 8'h00;
  int         pendParams = 0;

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 8'h%02h, expected 8'h%02h", tag, observed, expected);
    end
  endtask

  // Reference command table: what each finished command should leave in the FIFO.
  task automatic modelResponses(input logic [7:0] c);
    case (c)
      8'h02, 8'h06, 8'h0A, 8'h0B, 8'h12: expQ.push_back(8'h00);
      8'h20: begin
        expQ.push_back(8'h00);
        expQ.push_back(8'h21);
      end
      8'h00: ;
      default: expQ.push_back(8'hFF);
    endcase
  endtask

  // One bus access: sel rises at a falling clock edge, dout sampled 1 unit later.
  task automatic applyStimulus(input logic [1:0] addr, input logic wrFlag,
                               input logic [7:0] data, output logic [7:0] rd);
    @(negedge clk_sys);
    bus.sel     = 1'b1;
    bus.address = addr;
    bus.wr      = wrFlag;
    bus.din     = data;
    #1 rd = bus.dout;
    @(negedge clk_sys);
    bus.sel = 1'b0;
    bus.wr  = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic writeCmd(input logic [7:0] c);
    applyStimulus(2'b10, 1'b1, c, rdata);
    expQ.delete();
    pendCmd    = c;
    pendParams = (c == 8'h20 || c == 8'h00) ? 0 : 1;
    if (pendParams == 0) modelResponses(c);
  endtask

  task automatic writeData(input logic [7:0] d);
    applyStimulus(2'b00, 1'b1, d, rdata);
    if (pendParams > 0) begin
      pendParams--;
      if (pendParams == 0) modelResponses(pendCmd);
    end
  endtask

  task automatic readData(input string tag);
    logic [7:0] exp;
    applyStimulus(2'b00, 1'b0, 8'h00, rdata);
    exp = (expQ.size() > 0) ? expQ.pop_front() : 8'hFF;
    checkOutput(tag, rdata, exp);
  endtask

  task automatic readStatus(input string tag, input logic [7:0] exp);
    applyStimulus(2'b01, 1'b0, 8'h00, rdata);
    checkOutput(tag, rdata, exp);
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (bus.busy && n < 20 * BUSY_CYCLES) begin
      @(negedge clk_sys);
      n++;
    end
    checkOutput(tag, {7'd0, bus.busy}, 8'h00);
  endtask

  // Main stimulus sequence.
  initial begin
    logic [7:0] peek;
    int         n;
    logic       found;
    bus.ce      = 1'b1;
    bus.sel     = 1'b0;
    bus.address = 2'b00;
    bus.wr      = 1'b0;
    bus.din     = 8'h00;

    repeat (3) @(negedge clk_sys);
    checkOutput("resetBusy", {7'd0, bus.busy}, 8'h00);
    checkOutput("resetDout", bus.dout, 8'hFF);
    reset_n = 1'b1;
    @(negedge clk_sys);

    readStatus("idleStatus", 8'hB2);
    readData("emptyRead");
    readStatus("emptyReadNoEffect", 8'hB2);

    writeCmd(8'h12);
    writeData(8'h05);
    readStatus("busyStatus", 8'hB4);
    checkOutput("busyPin", {7'd0, bus.busy}, 8'h01);
    waitIdle("idle12");
    readStatus("pendingStatus", 8'hB1);
    readData("resp12");
    readStatus("drainedStatus", 8'hB2);

    writeCmd(8'h20);
    waitIdle("idle20");
    readData("ver0");
    readData("ver1");
    readData("verEmpty");

    writeCmd(8'h77);
    writeData(8'h00);
    waitIdle("idle77");
    readData("resp77");
    readStatus("after77", 8'hB2);
    writeData(8'hAA);
    readStatus("ovfStatus", 8'hBA);
    writeCmd(8'h00);
    waitIdle("idleNop");
    readStatus("ovfCleared", 8'hB2);

    writeCmd(8'h20);
    repeat (4) @(negedge clk_sys);
    writeCmd(8'h02);
    writeData(8'h33);
    waitIdle("idleAbort");
    readData("abortResp");
    readData("abortEmpty");
    readStatus("abortStatus", 8'hB2);

    writeCmd(8'h20);
    waitIdle("idleHold");
    @(negedge clk_sys);
    bus.sel     = 1'b1;
    bus.address = 2'b00;
    bus.wr      = 1'b0;
    #1;
    peek = expQ.pop_front();
    checkOutput("holdFirst", bus.dout, peek);
    repeat (4) @(negedge clk_sys);
    #1;
    checkOutput("holdStill", bus.dout, expQ[0]);
    bus.ce = 1'b0;
    #1;
    checkOutput("ceLowDout", bus.dout, 8'hFF);
    bus.ce = 1'b1;
    @(negedge clk_sys);
    bus.sel = 1'b0;
    @(negedge clk_sys);
    readStatus("holdPending", 8'hB1);
    readData("holdSecond");
    readData("holdEmpty");

    writeCmd(8'h20);
    @(negedge clk_sys);
    bus.sel     = 1'b1;
    bus.address = 2'b01;
    bus.wr      = 1'b0;
    n     = 0;
    found = 1'b0;
    while (!found && n < 20 * BUSY_CYCLES) begin
      @(negedge clk_sys);
      #1;
      found = bus.dout[0];
      n++;
    end
    checkOutput("respStatus", bus.dout, 8'hB5);
    reset_n = 1'b0;
    bus.sel = 1'b0;
    expQ.delete();
    pendParams = 0;
    #1;
    checkOutput("midResetBusy", {7'd0, bus.busy}, 8'h00);
    checkOutput("midResetDout", bus.dout, 8'hFF);
    @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
    readStatus("postResetStatus", 8'hB2);
    readData("postResetEmpty");

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

  // Last-resort bound on simulation time.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
